he_enc_arb_ctrl: RTL and testbench
==================================

Name: he_enc_arb_ctrl

Overview:
- Shares one fixed-latency Hamming encoder among NUM_REQ requesters.
- Each cycle it grants at most one requester round-robin, forwards that requester's data word to the encoder, and tags the word with the requester ID.
- When the codeword emerges it is returned with the matching ID.
- Sits between the requester ports and the encoder core; runs on the clock/reset pair from the block's clock/reset controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, message width into the encoder.
- CODE_W, 7, codeword width out of the encoder.
- ENC_LAT, 2, encoder latency in cycles from enc_in_valid to enc_out_valid (1..8).
- ID_W (localparam), $clog2(NUM_REQ), requester-ID width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  grant enable; low stops new grants, in-flight words drain.
- req_valid  input  NUM_REQ  per-requester request.
- req_data  input  NUM_REQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- enc_in_valid  output  1  word valid to encoder.
- enc_in_data  output  DATA_W  word to encoder.
- enc_out_valid  input  1  encoder result valid.
- enc_out_code  input  CODE_W  encoder codeword.
- rsp_valid  output  1  response valid, a one-cycle pulse with no backpressure.
- rsp_id  output  ID_W  requester ID of the response.
- rsp_code  output  CODE_W  returned codeword.
- idle  output  1  high when nothing is in flight and no grant is being issued.
- err  output  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset (rst_n low at a clk edge) forces:
  - rr_ptr=0, tag pipe cleared, inflight=0, state=IDLE.
  - rsp_valid=0, rsp_id=0, rsp_code=0, err=0, idle=1.
  - Combinational outputs during reset: req_ready=0, enc_in_valid=0, enc_in_data=0.
- Reset mid-operation discards all in-flight tags. Any enc_out_valid arriving after reset, with no tag, sets err.
- Grant (combinational, same cycle):
  - Condition: rst_n=1, en=1 and any req_valid set.
  - Grant goes to the first requester with req_valid set, searching indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is one-hot on the granted requester.
  - enc_in_valid=1 and enc_in_data = that requester's slice.
  - With no grant: req_ready=0, enc_in_valid=0, enc_in_data=0.
- rr_ptr: on a grant to requester g it becomes (g+1) mod NUM_REQ; it holds otherwise. Wrap from NUM_REQ-1 goes to 0.
- Tag pipe: ENC_LAT stages of {vld, id}.
  - Stage 0 is loaded with {enc_in_valid, granted id} each cycle; the stages shift every cycle.
  - The last stage aligns with enc_out_valid.
- Response (registered, +1 cycle):
  - rsp_valid <= enc_out_valid & tag_vld_last.
  - rsp_id <= tag_id_last and rsp_code <= enc_out_code, both captured when valid; outputs hold otherwise.
  - Total latency from grant to rsp_valid is ENC_LAT+1 cycles.
- err is set, and stays set until reset, when enc_out_valid != tag_vld_last. A mismatched result produces no response.
- inflight counter:
  - Width covers 0..ENC_LAT+1.
  - Increments on a grant, decrements on rsp_valid; simultaneous grant and response leave it unchanged.
  - Never exceeds ENC_LAT+1.
- FSM:
  - IDLE: inflight=0 and no grant. Goes to ACTIVE on a grant.
  - ACTIVE: goes to DRAIN when en=0 and inflight>0. Goes to IDLE when inflight reaches 0 with no grant.
  - DRAIN: no grants. Goes to ACTIVE if en returns high with a request. Goes to IDLE when inflight=0.
  - idle=1 only in IDLE.
- Full throughput: one grant per cycle is sustained indefinitely. With all requesters valid, grants rotate 0,1,2,3,0,...
- en deasserted in the same cycle a request arrives: no grant.

Decomposition:
- Package he_ctrl_pkg holds:
  - state enum {IDLE, ACTIVE, DRAIN}.
  - A tag struct {vld, id} parameterised by ID_W via localparam defaults.
  - The MAX_NUM_REQ constant.
- Sub-module he_rr_arb is a combinational round-robin priority picker: inputs req vector and rr_ptr; outputs one-hot grant and encoded index.
- Pointer update, tag pipe, response register and FSM stay in he_enc_arb_ctrl.

Test Plan:
- Reset and single request:
  - Hold rst_n=0 for 4 cycles with req_valid=4'b1111 → req_ready=0, enc_in_valid=0, rsp_valid=0, idle=1, err=0.
  - Release reset; raise req_valid[2] only with data 4'hB at cycle t → req_ready=4'b0100 at t, enc_in_data=4'hB.
  - Response at t+3 (ENC_LAT=2): rsp_valid=1, rsp_id=2, rsp_code = encoder model output for 4'hB.
- Round-robin fairness: all four valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical, delayed by 3 cycles; rsp_valid high for 8 consecutive cycles.
- Pointer wrap and skip: req_valid=4'b1001 after a grant to requester 3 → next grant is 0, then 3, then 0.
- Drain:
  - Drop en to 0 after 2 back-to-back grants → no further req_ready; 2 responses still appear.
  - FSM goes ACTIVE→DRAIN→IDLE; idle=1 the cycle after the last response.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 2 words in flight → no rsp_valid afterwards, inflight=0. The encoder model's stale enc_out_valid sets err=1, which holds until the next reset.
- Spurious result: pulse enc_out_valid with an empty tag pipe → err=1, rsp_valid stays 0.

Source files
------------

// File: rtl/he_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// he_ctrl_pkg
// Shared types for the Hamming-encoder arbiter/controller.
//   state_t     : controller FSM states (IDLE / ACTIVE / DRAIN)
//   tag_t       : per-stage in-flight tag {vld, id}. The id field is sized for
//                 the largest supported requester count, so any legal NUM_REQ
//                 fits; narrower IDs are zero-extended into it.
//   MAX_NUM_REQ : upper bound on the number of requesters.
// -----------------------------------------------------------------------------
package he_ctrl_pkg;

    localparam int MAX_NUM_REQ = 8;
    localparam int TAG_ID_W    = $clog2(MAX_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/he_rr_arb.sv
// -----------------------------------------------------------------------------
// he_rr_arb
// Combinational round-robin priority picker. Searches i_req starting at index
// i_ptr and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   i_req [NUM_REQ]  request vector
//   i_ptr [ID_W]     highest-priority index this cycle
//   o_gnt [NUM_REQ]  one-hot grant (zero when no request)
//   o_idx [ID_W]     encoded index of the grant (zero when no request)
//   o_any            at least one request present
// -----------------------------------------------------------------------------
module he_rr_arb
    import he_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    // Walk offsets from farthest to nearest so the nearest requester at or
    // after the pointer is the last assignment, and therefore the winner.
    always_comb begin
        int w_j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = ID_W'(w_j);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/he_enc_arb_ctrl.sv
// -----------------------------------------------------------------------------
// he_enc_arb_ctrl
// Shares one fixed-latency Hamming encoder among NUM_REQ requesters. At most
// one requester is granted per cycle (round-robin), its word is forwarded to
// the encoder, and its ID rides a tag pipe matched to the encoder latency so
// the returning codeword is delivered with the right ID one cycle later.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              grant enable (low: no new grants, in-flight words drain)
//   req_valid/data  per-requester request; word i at [i*DATA_W +: DATA_W]
//   req_ready       one-hot grant (combinational)
//   enc_in_*        word to encoder (combinational)
//   enc_out_*       encoder result, ENC_LAT cycles after enc_in_valid
//   rsp_*           registered response pulse with requester ID
//   idle            nothing in flight and no grant being issued
//   err             sticky: encoder valid disagreed with the tag pipe
// -----------------------------------------------------------------------------
module he_enc_arb_ctrl
    import he_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 4,
    parameter  int CODE_W  = 7,
    parameter  int ENC_LAT = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        enc_in_valid,
    output logic [DATA_W-1:0]           enc_in_data,
    input  logic                        enc_out_valid,
    input  logic [CODE_W-1:0]           enc_out_code,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [CODE_W-1:0]           rsp_code,
    output logic                        idle,
    output logic                        err
);

    // Counter must hold ENC_LAT+1: a grant stays counted until the cycle
    // after its response pulse.
    localparam int IF_W = $clog2(ENC_LAT + 2);

    logic [NUM_REQ-1:0]     w_arb_gnt;
    logic [ID_W-1:0]        w_arb_idx;
    logic                   w_arb_any;
    logic                   w_gnt;
    logic [ID_W-1:0]        w_ptr_nxt;
    tag_t                   w_tag_in;
    tag_t                   w_tag_last;
    logic                   w_hit;
    logic [IF_W-1:0]        w_inflight_nxt;

    logic [ID_W-1:0]        r_rr_ptr;
    tag_t [ENC_LAT-1:0]     r_tag;
    logic [IF_W-1:0]        r_inflight;
    state_t                 r_state;
    logic                   r_idle;
    logic                   r_rsp_valid;
    logic [ID_W-1:0]        r_rsp_id;
    logic [CODE_W-1:0]      r_rsp_code;
    logic                   r_err;

    he_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // Reset gates the grant so nothing leaks to the encoder while held.
    assign w_gnt        = rst_n & en & w_arb_any;
    assign req_ready    = w_gnt ? w_arb_gnt : '0;
    assign enc_in_valid = w_gnt;
    assign enc_in_data  = w_gnt ? req_data[w_arb_idx*DATA_W +: DATA_W] : '0;

    assign w_ptr_nxt    = (w_arb_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                             : w_arb_idx + ID_W'(1);

    assign w_tag_in.vld = w_gnt;
    assign w_tag_in.id  = w_gnt ? TAG_ID_W'(w_arb_idx) : '0;
    assign w_tag_last   = r_tag[ENC_LAT-1];
    assign w_hit        = enc_out_valid & w_tag_last.vld;

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_gnt && !r_rsp_valid)
            w_inflight_nxt = r_inflight + IF_W'(1);
        else if (!w_gnt && r_rsp_valid)
            w_inflight_nxt = r_inflight - IF_W'(1);
    end

    // Datapath: pointer, tag pipe, response register, error flag, counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_tag       <= '0;
            r_inflight  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_code  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_gnt)
                r_rr_ptr <= w_ptr_nxt;
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < ENC_LAT; i++)
                r_tag[i] <= r_tag[i-1];
            r_rsp_valid <= w_hit;
            if (w_hit) begin
                r_rsp_id   <= ID_W'(w_tag_last.id);
                r_rsp_code <= enc_out_code;
            end
            if (enc_out_valid != w_tag_last.vld)
                r_err <= 1'b1;
            r_inflight <= w_inflight_nxt;
        end
    end

    // Controller FSM. Decisions use the next-cycle in-flight count so idle
    // rises the cycle after the last response pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_state <= ACTIVE;
                        r_idle  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!en && w_inflight_nxt != '0) begin
                        r_state <= DRAIN;
                        r_idle  <= 1'b0;
                    end else if (!w_gnt && w_inflight_nxt == '0) begin
                        r_state <= IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_gnt) begin
                        r_state <= ACTIVE;
                        r_idle  <= 1'b0;
                    end else if (w_inflight_nxt == '0) begin
                        r_state <= IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_code  = r_rsp_code;
    assign idle      = r_idle;
    assign err       = r_err;

endmodule

// File: tb/tb_he_enc_arb_ctrl.sv
// Bench for he_enc_arb_ctrl: a behavioural 2-cycle Hamming(7,4) encoder sits
// on the encoder side; every accepted word pushes {id, codeword} onto a
// scoreboard that the response monitor pops in order.
module tb_he_enc_arb_ctrl;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int CODE_W  = 7;
    localparam int ENC_LAT = 2;

    typedef struct {
        logic [1:0] id;
        logic [6:0] code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        enc_in_valid;
    logic [3:0]  enc_in_data;
    logic        enc_out_valid;
    logic [6:0]  enc_out_code;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [6:0]  rsp_code;
    logic        idle;
    logic        err;
    logic        spur = 1'b0;

    int   n_chk = 0;
    int   n_err = 0;
    int   cur_run = 0;
    int   max_run = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    he_enc_arb_ctrl #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CODE_W  (CODE_W),
        .ENC_LAT (ENC_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .enc_in_valid  (enc_in_valid),
        .enc_in_data   (enc_in_data),
        .enc_out_valid (enc_out_valid),
        .enc_out_code  (enc_out_code),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_code      (rsp_code),
        .idle          (idle),
        .err           (err)
    );

    // Hamming(7,4), codeword bit order {d3,d2,d1,p3,d0,p2,p1}.
    function automatic logic [6:0] ham(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
    endfunction

    // Encoder model: free-running, not reset, so stale results survive a reset.
    logic       m0v = 1'b0, m1v = 1'b0;
    logic [3:0] m0d = 4'h0, m1d = 4'h0;
    always @(posedge clk) begin
        m0v <= enc_in_valid;
        m0d <= enc_in_data;
        m1v <= m0v;
        m1d <= m0d;
    end
    assign enc_out_valid = m1v | spur;
    assign enc_out_code  = ham(m1d);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_code", 32'(rsp_code), 32'(e.code));
            end
        end else begin
            cur_run = 0;
        end
    end

    // One cycle of stimulus; checks the combinational grant and queues the
    // expected response when a grant is expected.
    task automatic drive(input logic e, input logic [3:0] v, input logic [15:0] d,
                         input logic [3:0] exp_gnt);
        int   idx;
        exp_t x;
        @(negedge clk);
        en        = e;
        req_valid = v;
        req_data  = d;
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_gnt));
        chk("enc_in_valid", 32'(enc_in_valid), 32'(exp_gnt != 4'h0));
        if (exp_gnt != 4'h0) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (exp_gnt[i]) idx = i;
            chk("enc_in_data", 32'(enc_in_data), 32'(d[idx*4 +: 4]));
            x.id   = 2'(idx);
            x.code = ham(d[idx*4 +: 4]);
            sb.push_back(x);
        end else begin
            chk("enc_in_data0", 32'(enc_in_data), 32'd0);
        end
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = 4'hF;
        req_data  = 16'h1234;

        // Reset with all requests asserted.
        repeat (4) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_enc_vld", 32'(enc_in_valid), 32'd0);
        chk("rst_enc_data", 32'(enc_in_data), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(err), 32'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'h0;

        // Single request from requester 2, exact latency.
        drive(1'b1, 4'b0100, 16'h0B00, 4'b0100);
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        chk("lat_t1", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(idle), 32'd0);
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        chk("lat_t2", 32'(rsp_valid), 32'd0);
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        chk("lat_t3", 32'(rsp_valid), 32'd1);
        chk("lat_id", 32'(rsp_id), 32'd2);
        chk("lat_code", 32'(rsp_code), 32'(ham(4'hB)));
        wait_empty();

        // Grant to 3 puts the pointer back at 0, then full rotation.
        drive(1'b1, 4'b1000, 16'($urandom), 4'b1000);
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        wait_empty();
        max_run = 0;
        for (int c = 0; c < 8; c++)
            drive(1'b1, 4'b1111, 16'($urandom), 4'(1 << (c % 4)));
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        wait_empty();
        chk("rr_run", 32'(max_run), 32'd8);

        // Wrap and skip with requesters 0 and 3.
        drive(1'b1, 4'b1001, 16'($urandom), 4'b0001);
        drive(1'b1, 4'b1001, 16'($urandom), 4'b1000);
        drive(1'b1, 4'b1001, 16'($urandom), 4'b0001);
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        wait_empty();

        // Drain: two grants, then en low while requests stay asserted.
        drive(1'b1, 4'b1111, 16'($urandom), 4'b0010);
        drive(1'b1, 4'b1111, 16'($urandom), 4'b0100);
        drive(1'b0, 4'b1111, 16'($urandom), 4'b0000);
        chk("drn_idle0", 32'(idle), 32'd0);
        drive(1'b0, 4'b1111, 16'($urandom), 4'b0000);
        chk("drn_rsp1", 32'(rsp_valid), 32'd1);
        chk("drn_idle1", 32'(idle), 32'd0);
        drive(1'b0, 4'b1111, 16'($urandom), 4'b0000);
        chk("drn_rsp2", 32'(rsp_valid), 32'd1);
        chk("drn_idle2", 32'(idle), 32'd0);
        drive(1'b0, 4'b1111, 16'($urandom), 4'b0000);
        chk("drn_rsp3", 32'(rsp_valid), 32'd0);
        chk("drn_idle3", 32'(idle), 32'd1);
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        wait_empty();

        // Reset with two words in flight.
        drive(1'b1, 4'b0001, 16'($urandom), 4'b0001);
        drive(1'b1, 4'b0010, 16'($urandom), 4'b0010);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'h0;
        #1;
        sb.delete();
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_err0", 32'(err), 32'd0);
        chk("mid_rst_rsp0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("stale_err", 32'(err), 32'd1);
        chk("stale_rsp", 32'(rsp_valid), 32'd0);
        chk("stale_idle", 32'(idle), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);
        // Pointer restarts at 0 after reset.
        drive(1'b1, 4'b1111, 16'($urandom), 4'b0001);
        drive(1'b1, 4'b0000, 16'h0, 4'b0000);
        wait_empty();

        // Clear err, then a spurious encoder result.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("clr_err", 32'(err), 32'd0);
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        #1;
        chk("spur_err", 32'(err), 32'd1);
        chk("spur_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("spur_rsp2", 32'(rsp_valid), 32'd0);
        chk("spur_sticky", 32'(err), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
